// File: rtl/draw_sprite_pipe.sv
// Sprite compositor: rotates/mirrors a ROM sprite over a video stream,
// with colour-key transparency and a frame-counted flash on mouse hit.
module draw_sprite_pipe #(
  parameter int          W            = 53,
  parameter int          H            = 54,
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] KEY_RGB      = 12'h000,
  parameter logic [11:0] FLASH_RGB    = 12'hfff,
  parameter int          FLASH_FRAMES = 30,
  localparam int         AW = (W * H > 1) ? $clog2(W * H) : 1
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic [11:0]   hcount_in,
  input  logic [11:0]   vcount_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          hblnk_in,
  input  logic          vblnk_in,
  input  logic [11:0]   rgb_in,
  output logic [11:0]   hcount_out,
  output logic [11:0]   vcount_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          hblnk_out,
  output logic          vblnk_out,
  output logic [11:0]   rgb_out,
  input  logic [11:0]   sprite_x,
  input  logic [11:0]   sprite_y,
  input  logic [1:0]    rotation,
  input  logic          mirror,
  input  logic          enable,
  input  logic [11:0]   xpos,
  input  logic [11:0]   ypos,
  input  logic          mouse_left,
  output logic [AW-1:0] pixel_addr,
  input  logic [11:0]   rgb_pixel,
  output logic          hit
);

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        draw;
  } stage_t;

  logic [11:0] r_sx, r_sy;
  logic [1:0]  r_rot;
  logic        r_mir, r_en, r_vb_q;
  logic        r_ml, r_ml_q, r_hit;
  logic [7:0]  r_flash;
  logic [AW-1:0] r_addr;
  stage_t      r_p [0:ROM_LAT];
  logic [39:0] r_o;

  logic          w_vb_rise;
  logic [6:0]    w_bw, w_bh;
  logic          w_in_box, w_m_in, w_click;
  logic [6:0]    w_dx, w_dy, w_dxm, w_u, w_v;
  logic [AW-1:0] w_addr;
  stage_t        w_s0, w_s;
  logic [11:0]   w_rgb;

  // 13-bit compare so a box running past 4095 clips instead of wrapping
  function automatic logic in_span(input logic [11:0] p,
                                   input logic [11:0] s,
                                   input logic [6:0]  len);
    logic [12:0] p13, s13;
    p13 = {1'b0, p};
    s13 = {1'b0, s};
    return (p13 >= s13) && (p13 < s13 + 13'(len));
  endfunction

  assign w_vb_rise = vblnk_in & ~r_vb_q;
  assign w_bw = r_rot[0] ? 7'(H) : 7'(W);
  assign w_bh = r_rot[0] ? 7'(W) : 7'(H);

  assign w_in_box = in_span(hcount_in, r_sx, w_bw)
                 && in_span(vcount_in, r_sy, w_bh);
  assign w_m_in = in_span(xpos, r_sx, w_bw)
               && in_span(ypos, r_sy, w_bh);

  assign w_dx  = hcount_in[6:0] - r_sx[6:0];
  assign w_dy  = vcount_in[6:0] - r_sy[6:0];
  assign w_dxm = r_mir ? (w_bw - 7'd1 - w_dx) : w_dx;

  always_comb begin
    w_u = w_dxm;
    w_v = w_dy;
    unique case (r_rot)
      2'd0: begin
        w_u = w_dxm;
        w_v = w_dy;
      end
      2'd1: begin
        w_u = w_dy;
        w_v = 7'(H - 1) - w_dxm;
      end
      2'd2: begin
        w_u = 7'(W - 1) - w_dxm;
        w_v = 7'(H - 1) - w_dy;
      end
      default: begin
        w_u = 7'(W - 1) - w_dy;
        w_v = w_dxm;
      end
    endcase
  end

  assign w_addr = AW'(w_v) * AW'(W) + AW'(w_u);

  assign w_s0 = '{h: hcount_in, v: vcount_in,
                  hs: hsync_in, vs: vsync_in,
                  hb: hblnk_in, vb: vblnk_in,
                  rgb: rgb_in, draw: w_in_box & r_en};

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_sx   <= '0;
      r_sy   <= '0;
      r_rot  <= '0;
      r_mir  <= 1'b0;
      r_en   <= 1'b0;
      r_vb_q <= 1'b0;
    end else begin
      r_vb_q <= vblnk_in;
      if (w_vb_rise) begin
        r_sx  <= sprite_x;
        r_sy  <= sprite_y;
        r_rot <= rotation;
        r_mir <= mirror;
        r_en  <= enable;
      end
    end
  end

  // side-band delay line lines up with ROM data after ROM_LAT+1 stages
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_addr <= '0;
      for (int i = 0; i <= ROM_LAT; i++) r_p[i] <= '0;
    end else begin
      r_addr <= w_in_box ? w_addr : '0;
      r_p[0] <= w_s0;
      for (int i = 1; i <= ROM_LAT; i++) r_p[i] <= r_p[i-1];
    end
  end

  assign w_s = r_p[ROM_LAT];

  always_comb begin
    w_rgb = rgb_pixel;
    if (w_s.hb || w_s.vb)
      w_rgb = 12'h000;
    else if (!w_s.draw || rgb_pixel == KEY_RGB)
      w_rgb = w_s.rgb;
    else if (r_flash != 8'd0)
      w_rgb = FLASH_RGB;
  end

  always_ff @(posedge pclk) begin
    if (reset) r_o <= '0;
    else r_o <= {w_s.h, w_s.v, w_s.hs, w_s.vs,
                 w_s.hb, w_s.vb, w_rgb};
  end

  assign w_click = r_ml & ~r_ml_q & r_en & w_m_in;

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_ml    <= 1'b0;
      r_ml_q  <= 1'b0;
      r_hit   <= 1'b0;
      r_flash <= '0;
    end else begin
      r_ml   <= mouse_left;
      r_ml_q <= r_ml;
      r_hit  <= w_click;
      if (w_click)
        r_flash <= 8'(FLASH_FRAMES);
      else if (w_vb_rise && r_flash != 8'd0)
        r_flash <= r_flash - 8'd1;
    end
  end

  assign {hcount_out, vcount_out, hsync_out, vsync_out,
          hblnk_out, vblnk_out, rgb_out} = r_o;
  assign pixel_addr = r_addr;
  assign hit        = r_hit;

endmodule

// File: tb/tb_draw_sprite_pipe.sv
// Bench for draw_sprite_pipe: streams pixels against a geometric
// reference model and a bench-side sprite ROM with one-cycle latency.
module tb_draw_sprite_pipe;

  localparam int W  = 53;
  localparam int H  = 54;
  localparam int AW = 12;
  localparam logic [11:0] KEY = 12'h000;
  localparam logic [11:0] FLS = 12'hfff;
  localparam int FF = 30;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } pix_t;

  logic pclk = 0, reset = 1;
  logic [11:0] hcount_in = 0, vcount_in = 0, rgb_in = 0;
  logic hsync_in = 0, vsync_in = 0, hblnk_in = 0, vblnk_in = 0;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] sprite_x = 0, sprite_y = 0, xpos = 0, ypos = 0;
  logic [1:0] rotation = 0;
  logic mirror = 0, enable = 0, mouse_left = 0;
  logic [AW-1:0] pixel_addr;
  logic [11:0] rgb_pixel = 0;
  logic hit;

  logic [11:0] rom [W*H];
  pix_t act;
  pix_t q[$];
  int n_chk = 0, n_fail = 0, hit_cnt = 0;
  int m_sx, m_sy, m_rot, m_mir, m_en, m_flash, m_addr;
  bit m_vbp, m_inb;

  draw_sprite_pipe dut (
    .pclk(pclk), .reset(reset),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .rotation(rotation), .mirror(mirror), .enable(enable),
    .xpos(xpos), .ypos(ypos), .mouse_left(mouse_left),
    .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel), .hit(hit)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk)
    rgb_pixel <= (int'(pixel_addr) < W*H) ? rom[pixel_addr] : 12'h0;

  always @(negedge pclk) if (hit) hit_cnt++;

  assign act = {hcount_out, vcount_out, hsync_out, vsync_out,
                hblnk_out, vblnk_out, rgb_out};

  function automatic pix_t px(input int h, v,
                              input logic [11:0] rgb,
                              input bit hb, vb);
    pix_t p;
    p.h = h[11:0]; p.v = v[11:0];
    p.hs = 0; p.vs = 0;
    p.hb = hb; p.vb = vb; p.rgb = rgb;
    return p;
  endfunction

  function automatic void model(input pix_t p, output pix_t e,
                                output int addr, output bit inb);
    int bw, bh, dx, dy, u, v;
    bw = (m_rot % 2) ? H : W;
    bh = (m_rot % 2) ? W : H;
    dx = int'(p.h) - m_sx;
    dy = int'(p.v) - m_sy;
    inb = dx >= 0 && dx < bw && dy >= 0 && dy < bh;
    if (m_mir != 0) dx = bw - 1 - dx;
    case (m_rot)
      0: begin u = dx; v = dy; end
      1: begin u = dy; v = H - 1 - dx; end
      2: begin u = W - 1 - dx; v = H - 1 - dy; end
      default: begin u = W - 1 - dy; v = dx; end
    endcase
    addr = inb ? v * W + u : 0;
    e = p;
    if (p.hb || p.vb) e.rgb = 12'h000;
    else if (!inb || m_en == 0) e.rgb = p.rgb;
    else if (rom[addr] == KEY) e.rgb = p.rgb;
    else if (m_flash != 0) e.rgb = FLS;
    else e.rgb = rom[addr];
  endfunction

  task automatic step(input pix_t p, output bit have, output pix_t e);
    pix_t x;
    hcount_in = p.h; vcount_in = p.v;
    hsync_in = p.hs; vsync_in = p.vs;
    hblnk_in = p.hb; vblnk_in = p.vb; rgb_in = p.rgb;
    model(p, x, m_addr, m_inb);
    q.push_back(x);
    if (p.vb && !m_vbp) begin
      m_sx = sprite_x; m_sy = sprite_y; m_rot = rotation;
      m_mir = mirror; m_en = enable;
      if (m_flash > 0) m_flash--;
    end
    m_vbp = p.vb;
    @(posedge pclk); #1;
    have = 0; e = '0;
    if (q.size() == 3) begin e = q.pop_front(); have = 1; end
  endtask

  task automatic geom(input int x, y, r, m, en);
    sprite_x = x[11:0]; sprite_y = y[11:0];
    rotation = r[1:0]; mirror = m[0]; enable = en[0];
  endtask

  task automatic frame_edge();
    bit hv; pix_t e;
    for (int i = 0; i < 6; i++)
      step(px(0, 0, 12'h0, 1'b1, (i == 2 || i == 3)), hv, e);
  endtask

  task automatic click(input int x, y, output int hits);
    bit hv; pix_t e; int h0;
    h0 = hit_cnt;
    xpos = x[11:0]; ypos = y[11:0]; mouse_left = 1;
    repeat (6) step(px(0, 0, 12'h0, 1'b1, 1'b0), hv, e);
    mouse_left = 0;
    repeat (4) step(px(0, 0, 12'h0, 1'b1, 1'b0), hv, e);
    hits = hit_cnt - h0;
  endtask

  task automatic clear_model();
    q.delete();
    m_sx = 0; m_sy = 0; m_rot = 0; m_mir = 0; m_en = 0;
    m_flash = 0; m_vbp = 0;
  endtask

  task automatic test_reset();
    bit hv; pix_t e, p;
    reset = 1;
    hcount_in = 12'd5; rgb_in = 12'habc; hsync_in = 1;
    mouse_left = 1; geom(100, 100, 0, 0, 1);
    repeat (3) @(posedge pclk);
    #1;
    n_chk++;
    if (act !== '0) begin
      n_fail++; $display("FAIL reset_out got %h exp 0", act);
    end
    n_chk++;
    if (pixel_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr got %h exp 0", pixel_addr);
    end
    n_chk++;
    if (hit !== 1'b0) begin
      n_fail++; $display("FAIL reset_hit got %b exp 0", hit);
    end
    mouse_left = 0; hsync_in = 0; vblnk_in = 0;
    clear_model();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      p = (i < 2) ? px(100 + i, 100, 12'h5a5, 0, 0) : px(0, 0, 0, 1, 0);
      step(p, hv, e);
      if (hv) begin
        n_chk++;
        if (act !== e) begin
          n_fail++; $display("FAIL reset_nodraw got %h exp %h", act, e);
        end
      end
    end
  endtask

  task automatic test_addr();
    int ph[3][2], pv[3][2], pa[3][2];
    bit hv; pix_t e, p;
    ph = '{'{100, 152}, '{53, 0}, '{0, 52}};
    pv = '{'{100, 153}, '{0, 52}, '{0, 53}};
    pa = '{'{0, 2861}, '{0, 2861}, '{52, 2809}};
    for (int c = 0; c < 3; c++) begin
      if (c == 0) geom(100, 100, 0, 0, 1);
      else if (c == 1) geom(0, 0, 1, 0, 1);
      else geom(0, 0, 0, 1, 1);
      frame_edge();
      for (int i = 0; i < 4; i++) begin
        p = (i < 2) ? px(ph[c][i], pv[c][i], 12'h321, 0, 0)
                    : px(0, 0, 0, 1, 0);
        step(p, hv, e);
        if (i < 2) begin
          n_chk++;
          if (pixel_addr !== AW'(pa[c][i])) begin
            n_fail++;
            $display("FAIL addr cfg%0d got %0d exp %0d",
                     c, pixel_addr, pa[c][i]);
          end
        end
        if (hv) begin
          n_chk++;
          if (act !== e) begin
            n_fail++; $display("FAIL addr_pix got %h exp %h", act, e);
          end
        end
      end
    end
  endtask

  task automatic test_key_blank();
    bit hv; pix_t e, p;
    geom(100, 100, 0, 0, 1);
    frame_edge();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: p = px(101, 100, 12'h0a5, 0, 0);
        1: p = px(100, 100, 12'h0a5, 1, 0);
        2: p = px(100, 100, 12'h0a5, 0, 0);
        default: p = px(0, 0, 0, 1, 0);
      endcase
      step(p, hv, e);
      if (hv) begin
        n_chk++;
        if (act !== e) begin
          n_fail++; $display("FAIL key_blank got %h exp %h", act, e);
        end
      end
    end
  endtask

  task automatic test_midframe();
    bit hv; pix_t e, p;
    geom(100, 100, 0, 0, 1);
    frame_edge();
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 1) sprite_x = 12'd300;
      if (ph == 2) frame_edge();
      for (int i = 0; i < 4; i++) begin
        if (i == 0) p = px(100, 100, 12'h777, 0, 0);
        else if (i == 1) p = px(300, 100, 12'h778, 0, 0);
        else p = px(0, 0, 0, 1, 0);
        step(p, hv, e);
        if (hv) begin
          n_chk++;
          if (act !== e) begin
            n_fail++; $display("FAIL midframe got %h exp %h", act, e);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    bit hv; pix_t e, p;
    int sx, sy, bw, bh;
    for (int r = 0; r < 6; r++) begin
      sx = (r == 5) ? 4070 : int'($urandom_range(0, 300));
      sy = (r == 5) ? 4080 : int'($urandom_range(0, 300));
      geom(sx, sy, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           (r == 4) ? 0 : 1);
      frame_edge();
      bw = rotation[0] ? H : W;
      bh = rotation[0] ? W : H;
      for (int i = 0; i < 62; i++) begin
        if (i < 60) begin
          p = px(sx - 5 + int'($urandom_range(0, bw + 10)),
                 sy - 5 + int'($urandom_range(0, bh + 10)),
                 12'($urandom), ($urandom_range(0, 15) == 0), 0);
          p.hs = 1'($urandom); p.vs = 1'($urandom);
        end else p = px(0, 0, 0, 1, 0);
        step(p, hv, e);
        if (i < 60 && m_inb) begin
          n_chk++;
          if (pixel_addr !== AW'(m_addr)) begin
            n_fail++;
            $display("FAIL rand_addr got %0d exp %0d", pixel_addr, m_addr);
          end
        end
        if (hv) begin
          n_chk++;
          if (act !== e) begin
            n_fail++; $display("FAIL rand_pix got %h exp %h", act, e);
          end
        end
      end
    end
  endtask

  task automatic test_flash();
    bit hv; pix_t e, p; int hits;
    geom(100, 100, 0, 0, 1);
    frame_edge();
    click(126, 127, hits);
    n_chk++;
    if (hits !== 1) begin
      n_fail++; $display("FAIL click_hit got %0d exp 1", hits);
    end
    m_flash = FF;
    for (int n = 0; n < 45; n++) begin
      if (n == 10) begin
        click(110, 140, hits);
        n_chk++;
        if (hits !== 1) begin
          n_fail++; $display("FAIL reclick_hit got %0d exp 1", hits);
        end
        m_flash = FF;
      end
      for (int i = 0; i < 3; i++) begin
        p = (i == 0) ? px(100, 100, 12'h456, 0, 0) : px(0, 0, 0, 1, 0);
        step(p, hv, e);
        if (hv) begin
          n_chk++;
          if (act !== e) begin
            n_fail++;
            $display("FAIL flash n=%0d got %h exp %h", n, act, e);
          end
        end
      end
      frame_edge();
    end
  endtask

  task automatic test_click_neg();
    bit hv; pix_t e, p; int hits;
    click(0, 0, hits);
    n_chk++;
    if (hits !== 0) begin
      n_fail++; $display("FAIL click_outside got %0d exp 0", hits);
    end
    geom(100, 100, 0, 0, 0);
    frame_edge();
    click(126, 127, hits);
    n_chk++;
    if (hits !== 0) begin
      n_fail++; $display("FAIL click_disabled got %0d exp 0", hits);
    end
    for (int i = 0; i < 3; i++) begin
      p = (i == 0) ? px(100, 100, 12'h0f0, 0, 0) : px(0, 0, 0, 1, 0);
      step(p, hv, e);
      if (hv) begin
        n_chk++;
        if (act !== e) begin
          n_fail++; $display("FAIL disabled_pix got %h exp %h", act, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hv; pix_t e, p; int hits;
    geom(100, 100, 0, 0, 1);
    frame_edge();
    click(126, 127, hits);
    n_chk++;
    if (hits !== 1) begin
      n_fail++; $display("FAIL mid_click got %0d exp 1", hits);
    end
    reset = 1;
    @(posedge pclk); #1;
    n_chk++;
    if (act !== '0) begin
      n_fail++; $display("FAIL mid_reset_out got %h exp 0", act);
    end
    @(posedge pclk); #1;
    clear_model();
    reset = 0;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) frame_edge();
      for (int i = 0; i < 3; i++) begin
        p = (i == 0) ? px(100, 100, 12'h3c3, 0, 0) : px(0, 0, 0, 1, 0);
        step(p, hv, e);
        if (hv) begin
          n_chk++;
          if (act !== e) begin
            n_fail++;
            $display("FAIL mid_reset ph%0d got %h exp %h", ph, act, e);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < W*H; i++) begin
      rom[i] = 12'($urandom);
      if ($urandom_range(0, 7) == 0) rom[i] = KEY;
    end
    rom[0] = 12'h123;
    rom[1] = KEY;
    clear_model();
    test_reset();
    test_addr();
    test_key_blank();
    test_midframe();
    test_random();
    test_flash();
    test_click_neg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
